// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with wait states, byte strobes and word-addressed memory
module apb_slave_mem #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 16,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'(SW - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    write_q, write_d;
    logic [SW-1:0]           strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];

    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic [IW-1:0]            idx_in;
    logic                     err_in;
    logic                     unused_pprot;

    assign word_idx     = paddr >> LSB;
    assign idx_in       = word_idx[IW-1:0];
    assign err_in       = (|(paddr & OFF_MASK)) || (word_idx >= ADDRESS_WIDTH'(MEM_DEPTH));
    assign unused_pprot = ^pprot;

    assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !write_q && !err_q) ? rdata_q : '0;

    // Next state: latch the transfer at setup, count wait states, commit writes on completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        if (state_q == IDLE) begin
            if (psel && !penable) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_CYCLES);
                idx_d   = idx_in;
                write_d = pwrite;
                strb_d  = pstrb;
                wdata_d = pwdata;
                err_d   = err_in;
                rdata_d = err_in ? '0 : mem_q[idx_in];
            end
        end else if (!psel) begin
            state_d = IDLE;
        end else if (penable) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
                if (write_q && !err_q) begin
                    for (int i = 0; i < SW; i++) begin
                        if (strb_q[i]) mem_d[idx_q][8*i +: 8] = wdata_q[8*i +: 8];
                    end
                end
            end
        end
    end

    // State and memory registers; reset clears everything including memory
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed APB transfers checked cycle by cycle against a byte-array model
module tb_apb_slave_mem;
    localparam int W = 2;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [3:0]  pstrb = '0;
    logic [31:0] pwdata = '0;
    logic [2:0]  pprot = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    apb_slave_mem #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_CYCLES(W)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    logic [7:0]  mdl [64];
    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_pready = 1'b0;
    logic        exp_pslverr = 1'b0;
    logic [31:0] exp_prdata = '0;
    logic        run = 1'b0;
    int          lowcnt = 0;
    int          cap_low = 0;
    logic [31:0] cap_prdata = '0;
    logic        cap_slverr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
    endfunction

    function automatic bit merr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd16);
    endfunction

    task automatic set_exp(input logic r, input logic e, input logic [31:0] d);
        exp_pready = r;
        exp_pslverr = e;
        exp_prdata = d;
    endtask

    // Per-cycle comparison of every output against the model, plus capture of completion results
    always @(negedge pclk) begin
        if (run) begin
            chk("pready", {31'b0, pready}, {31'b0, exp_pready});
            chk("pslverr", {31'b0, pslverr}, {31'b0, exp_pslverr});
            chk("prdata", prdata, exp_prdata);
            if (psel && !penable) lowcnt = 0;
            else if (psel && penable && !pready) lowcnt++;
            if (pready) begin
                cap_low = lowcnt;
                cap_prdata = prdata;
                cap_slverr = pslverr;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            psel = 1'b0;
            penable = 1'b0;
            set_exp(1'b0, 1'b0, '0);
            @(posedge pclk); #1;
        end
    endtask

    // mode 0: normal, 1: psel dropped at second access cycle, 2: reset during final access cycle
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [3:0] st,
                        input logic [31:0] d, input int mode);
        bit e;
        logic [31:0] rd;
        e = merr(a);
        rd = (e || wr) ? 32'h0 : mword(int'(a));
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pstrb = st; pwdata = d;
        pprot = 3'($urandom);
        set_exp(1'b0, 1'b0, '0);
        @(posedge pclk); #1;
        for (int k = 0; k <= W; k++) begin
            psel = 1'b1; penable = 1'b1;
            paddr = $urandom; pwdata = $urandom; pwrite = ~wr; pstrb = 4'($urandom);
            if (mode == 1 && k == 1) begin
                psel = 1'b0; penable = 1'b0;
            end
            set_exp(k == W, (k == W) && e, (k == W) ? rd : 32'h0);
            if (mode == 2 && k == W) begin
                @(negedge pclk); #1;
                preset_n = 1'b0;
                set_exp(1'b0, 1'b0, '0);
                #1;
                chk("rst_pready", {31'b0, pready}, 32'h0);
                chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
                chk("rst_prdata", prdata, 32'h0);
                psel = 1'b0; penable = 1'b0;
                @(posedge pclk); #1;
                preset_n = 1'b1;
                for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
                return;
            end
            @(posedge pclk); #1;
            if (mode == 1 && k == 1) return;
        end
        if (wr && !e)
            for (int i = 0; i < 4; i++)
                if (st[i]) mdl[int'(a) + i] = d[8*i +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: no summary after %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        run = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        idle(1);

        xfer(32'h04, 1'b0, 4'h0, 32'h0, 0);
        chk("r04_prdata", cap_prdata, 32'h0);
        chk("r04_slverr", {31'b0, cap_slverr}, 32'h0);
        chk("r04_wait", 32'(cap_low), 32'd2);

        xfer(32'h08, 1'b1, 4'hF, 32'hDEADBEEF, 0);
        xfer(32'h08, 1'b1, 4'h5, 32'h11223344, 0);
        xfer(32'h08, 1'b0, 4'h0, 32'h0, 0);
        chk("strb_merge", cap_prdata, 32'hDE22BE44);

        xfer(32'h40, 1'b0, 4'h0, 32'h0, 0);
        chk("oob_slverr", {31'b0, cap_slverr}, 32'h1);
        chk("oob_prdata", cap_prdata, 32'h0);
        xfer(32'h06, 1'b1, 4'hF, 32'hCAFEF00D, 0);
        chk("mis_slverr", {31'b0, cap_slverr}, 32'h1);
        xfer(32'h04, 1'b0, 4'h0, 32'h0, 0);
        chk("mis_nowrite04", cap_prdata, 32'h0);
        xfer(32'h08, 1'b0, 4'h0, 32'h0, 0);
        chk("mis_nowrite08", cap_prdata, 32'hDE22BE44);

        xfer(32'h0C, 1'b1, 4'hF, 32'hA5A5A5A5, 0);
        xfer(32'h0C, 1'b0, 4'h0, 32'h0, 0);
        chk("b2b_prdata", cap_prdata, 32'hA5A5A5A5);
        xfer(32'h0C, 1'b1, 4'h0, 32'hFFFFFFFF, 0);
        chk("strb0_slverr", {31'b0, cap_slverr}, 32'h0);
        xfer(32'h0C, 1'b0, 4'h0, 32'h0, 0);
        chk("strb0_prdata", cap_prdata, 32'hA5A5A5A5);

        xfer(32'h3C, 1'b1, 4'hF, 32'h0BADF00D, 0);
        xfer(32'h3C, 1'b0, 4'h0, 32'h0, 0);
        chk("last_word", cap_prdata, 32'h0BADF00D);

        idle(1);
        xfer(32'h10, 1'b1, 4'hF, 32'h12345678, 1);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 0);
        chk("abort_prdata", cap_prdata, 32'h0);

        psel = 1'b1; penable = 1'b1; paddr = 32'h08; pwrite = 1'b0;
        set_exp(1'b0, 1'b0, '0);
        repeat (2) begin
            @(posedge pclk); #1;
        end
        idle(1);

        xfer(32'h00, 1'b1, 4'hF, 32'hFFFFFFFF, 2);
        xfer(32'h00, 1'b0, 4'h0, 32'h0, 0);
        chk("rst_mem00", cap_prdata, 32'h0);
        xfer(32'h08, 1'b0, 4'h0, 32'h0, 0);
        chk("rst_mem08", cap_prdata, 32'h0);
        idle(2);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 32, paddr width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL provide parameter MEM_DEPTH, default 16, number of DATA_WIDTH-bit words.
REQ-004 SHALL provide parameter WAIT_CYCLES, default 2, pready-low cycles inserted per access phase (0..15).
REQ-005 SHALL have pclk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have preset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have psel  input  1  slave select.
REQ-008 SHALL have penable  input  1  access-phase indicator.
REQ-009 SHALL have paddr  input  ADDRESS_WIDTH  byte address.
REQ-010 SHALL have pwrite  input  1  1 = write, 0 = read.
REQ-011 SHALL have pstrb  input  DATA_WIDTH/8  write byte-lane strobes.
REQ-012 SHALL have pwdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have pprot  input  3  protection type; accepted, no functional effect.
REQ-014 SHALL have pready  output  1  transfer-complete / wait-state control.
REQ-015 SHALL have prdata  output  DATA_WIDTH  read data.
REQ-016 SHALL have pslverr  output  1  transfer error.

Function
REQ-017 SHALL implement FSM states IDLE and ACCESS.
REQ-018 IDLE: on a cycle with psel=1 and penable=0 (setup), SHALL go to ACCESS, load wait counter with WAIT_CYCLES, and latch paddr, pwrite, pstrb, pwdata, error flag and read data.
REQ-019 IDLE with penable=1 and no prior setup (protocol violation) SHALL be ignored; remain IDLE, pready=0.
REQ-020 ACCESS: wait counter SHALL decrement by 1 per cycle while psel=1, penable=1 and counter>0.
REQ-021 pready SHALL be combinational: 1 iff state=ACCESS and counter=0; otherwise 0.
REQ-022 Access phase SHALL last exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives zero-wait transfer.
REQ-023 Completion edge (psel=1, penable=1, pready=1) SHALL return FSM to IDLE; a back-to-back setup in the next cycle SHALL be accepted with no idle cycle.
REQ-024 psel=0 while in ACCESS (abort) SHALL return to IDLE on that edge with no memory update.
REQ-025 Word index = latched paddr >> log2(DATA_WIDTH/8).
REQ-026 Error flag SHALL be set when paddr low byte-offset bits are non-zero (misaligned) or word index >= MEM_DEPTH.
REQ-027 pslverr SHALL equal pready AND error flag; 0 at all other times.
REQ-028 Write without error SHALL update, at completion edge only, each byte lane i where pstrb[i]=1; lanes with pstrb[i]=0 unchanged; pstrb=0 writes nothing, no error.
REQ-029 Erroring write SHALL leave memory unchanged.
REQ-030 prdata SHALL carry latched word when pready=1, pwrite=0 and no error; 0 otherwise (including error reads).
REQ-031 Read data SHALL be sampled at setup edge; a write completing in the immediately preceding transfer SHALL be visible.
REQ-032 Inputs changed during ACCESS other than psel/penable SHALL be ignored (latched values used).

Reset
REQ-033 preset_n=0 SHALL immediately force FSM to IDLE, counter to 0, pready=0, prdata=0, pslverr=0, all memory words to 0.
REQ-034 Reset asserted mid-transfer SHALL abort it with no memory update; first setup after release SHALL be accepted normally.

Verification
REQ-035 Reset then read 0x04, WAIT_CYCLES=2 -> pready low 2 access cycles, high 3rd, prdata=0x00000000, pslverr=0.
REQ-036 Write 0x08 data 0xDEADBEEF pstrb=0xF, then write 0x08 data 0x11223344 pstrb=0x5, read 0x08 -> prdata=0xDE22BE44.
REQ-037 Read 0x40 (index 16) and write 0x06 (misaligned) -> pslverr=1 with pready, prdata=0, memory unchanged.
REQ-038 Back-to-back write 0x0C=0xA5A5A5A5 then read 0x0C, no idle cycle -> second setup accepted, prdata=0xA5A5A5A5.
REQ-039 Write 0x10=0x12345678 with psel dropped after 1 access cycle, then read 0x10 -> prdata=0x00000000.
REQ-040 preset_n asserted during access of write 0x00=0xFFFFFFFF -> pready=0 at once; after release read 0x00 -> 0x00000000.
